// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command decoder: parser states,
// ASCII codes and per-digit upper limits for the MMSS field.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIG0 = 3'd1,
    DIG1 = 3'd2,
    DIG2 = 3'd3,
    DIG3 = 3'd4,
    TERM = 3'd5
  } state_e;

  localparam logic [7:0] CH_L    = 8'h6c;
  localparam logic [7:0] CH_L_UP = 8'h4c;
  localparam logic [7:0] CH_A    = 8'h61;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_AT   = 8'h40;
  localparam logic [7:0] CH_ESC  = 8'h1b;
  localparam logic [7:0] CH_0    = 8'h30;

  // Largest legal value for minutes-tens, minutes-ones, seconds-tens, seconds-ones.
  localparam logic [3:0] MAX_MT = 4'd5;
  localparam logic [3:0] MAX_MO = 4'd9;
  localparam logic [3:0] MAX_ST = 4'd5;
  localparam logic [3:0] MAX_SO = 4'd9;

  function automatic logic is_load_cmd(input logic [7:0] ch);
    return (ch == CH_L) || (ch == CH_L_UP) || (ch == CH_A) || (ch == CH_A_UP);
  endfunction

endpackage

// File: rtl/ascii_digit_chk.sv
// Combinational ASCII digit check: ok when ch_i is '0'..('0'+max_i); bcd_o is its value.
module ascii_digit_chk
  import cmd_pkg::*;
(
  input  logic [7:0] ch_i,
  input  logic [3:0] max_i,
  output logic       ok_o,
  output logic [3:0] bcd_o
);

  logic [7:0] diff;

  assign diff  = ch_i - CH_0;
  // Bytes below '0' wrap to large values, so one unsigned compare covers both ends.
  assign ok_o  = (ch_i >= CH_0) && (diff <= {4'h0, max_i});
  assign bcd_o = diff[3:0];

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses l/a+MMSS+TERM_CHAR and '@' from the UART RX byte stream into load strobes.
// Optional byte echo on tx_data/tx_data_rdy when CMD_ECHO_EN is defined.
module uart_cmd_decoder
  import cmd_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR    = 8'h0d,
  parameter logic       ALARM_EN_RST = 1'b0
) (
  input  logic        clk12m,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic        ld_time,
  output logic        ld_alarm,
  output logic [15:0] bcd_val,
  output logic        alarm_en,
  output logic        cmd_err
`ifdef CMD_ECHO_EN
  ,
  output logic [7:0]  tx_data,
  output logic        tx_data_rdy
`endif
);

  state_e      state_q, state_d;
  logic        cmd_is_alarm_q, cmd_is_alarm_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] bcd_q, bcd_d;
  logic        alarm_en_q, alarm_en_d;
  logic        ld_time_q, ld_time_d;
  logic        ld_alarm_q, ld_alarm_d;
  logic        cmd_err_q, cmd_err_d;

  logic [3:0]  dig_max;
  logic        dig_ok;
  logic [3:0]  dig_bcd;

  always_comb begin
    dig_max = MAX_SO;
    unique case (state_q)
      DIG0:    dig_max = MAX_MT;
      DIG1:    dig_max = MAX_MO;
      DIG2:    dig_max = MAX_ST;
      DIG3:    dig_max = MAX_SO;
      default: dig_max = MAX_SO;
    endcase
  end

  ascii_digit_chk u_dig_chk (
    .ch_i  (rx_data),
    .max_i (dig_max),
    .ok_o  (dig_ok),
    .bcd_o (dig_bcd)
  );

  always_comb begin
    state_d        = state_q;
    cmd_is_alarm_d = cmd_is_alarm_q;
    shadow_d       = shadow_q;
    bcd_d          = bcd_q;
    alarm_en_d     = alarm_en_q;
    ld_time_d      = 1'b0;
    ld_alarm_d     = 1'b0;
    cmd_err_d      = 1'b0;
    if (rx_data_rdy) begin
      unique case (state_q)
        IDLE: begin
          if (is_load_cmd(rx_data)) begin
            state_d        = DIG0;
            cmd_is_alarm_d = (rx_data == CH_A) || (rx_data == CH_A_UP);
          end else if (rx_data == CH_AT) begin
            alarm_en_d = ~alarm_en_q;
          end
        end
        DIG0, DIG1, DIG2, DIG3: begin
          if (rx_data == CH_ESC) begin
            state_d = IDLE;
          end else if (dig_ok) begin
            unique case (state_q)
              DIG0: begin shadow_d[15:12] = dig_bcd; state_d = DIG1; end
              DIG1: begin shadow_d[11:8]  = dig_bcd; state_d = DIG2; end
              DIG2: begin shadow_d[7:4]   = dig_bcd; state_d = DIG3; end
              default: begin shadow_d[3:0] = dig_bcd; state_d = TERM; end
            endcase
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
        TERM: begin
          state_d = IDLE;
          if (rx_data == CH_ESC) begin
            state_d = IDLE;
          end else if (rx_data == TERM_CHAR) begin
            bcd_d      = shadow_q;
            ld_alarm_d = cmd_is_alarm_q;
            ld_time_d  = ~cmd_is_alarm_q;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_is_alarm_q <= 1'b0;
      shadow_q       <= 16'h0000;
      bcd_q          <= 16'h0000;
      alarm_en_q     <= ALARM_EN_RST;
      ld_time_q      <= 1'b0;
      ld_alarm_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_is_alarm_q <= cmd_is_alarm_d;
      shadow_q       <= shadow_d;
      bcd_q          <= bcd_d;
      alarm_en_q     <= alarm_en_d;
      ld_time_q      <= ld_time_d;
      ld_alarm_q     <= ld_alarm_d;
      cmd_err_q      <= cmd_err_d;
    end
  end

  assign ld_time  = ld_time_q;
  assign ld_alarm = ld_alarm_q;
  assign bcd_val  = bcd_q;
  assign alarm_en = alarm_en_q;
  assign cmd_err  = cmd_err_q;

`ifdef CMD_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_rdy_q;

  assign tx_data_d = rx_data_rdy ? rx_data : tx_data_q;

  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= 8'h00;
      tx_rdy_q  <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= rx_data_rdy;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_data_rdy = tx_rdy_q;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: directed test-plan sequences then random commands.
module tb_uart_cmd_decoder;

  localparam logic [7:0] TERM    = 8'h0d;
  localparam logic       EN_RST  = 1'b0;

  logic        clk12m = 1'b0;
  logic        rst_n  = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_rdy = 1'b0;
  logic        ld_time, ld_alarm, alarm_en, cmd_err;
  logic [15:0] bcd_val;
`ifdef CMD_ECHO_EN
  logic [7:0]  tx_data;
  logic        tx_data_rdy;
`endif

  uart_cmd_decoder #(.TERM_CHAR(TERM), .ALARM_EN_RST(EN_RST)) dut (
    .clk12m      (clk12m),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .ld_time     (ld_time),
    .ld_alarm    (ld_alarm),
    .bcd_val     (bcd_val),
    .alarm_en    (alarm_en),
    .cmd_err     (cmd_err)
`ifdef CMD_ECHO_EN
    ,
    .tx_data     (tx_data),
    .tx_data_rdy (tx_data_rdy)
`endif
  );

  always #5 clk12m = ~clk12m;

  // Event kinds: 0 ld_time, 1 ld_alarm, 2 cmd_err, 3 alarm_en toggle
  typedef struct {
    int          kind;
    logic [15:0] bcd;
    logic        en;
    int          cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   echo_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model: a command is a prefix of [cmd, d0..d3, TERM]; pos = bytes seen.
  int          pos = 0;
  bit          m_alarm = 1'b0;
  logic [3:0]  m_dig [4];
  logic [15:0] m_bcd = 16'h0000;
  logic        m_en  = EN_RST;
  int          maxtab [4] = '{5, 9, 5, 9};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind; e.bcd = m_bcd; e.en = m_en; e.cyc = c + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic [7:0] b, input int c);
    int v;
    v = int'(b);
    if (pos == 0) begin
      if (b == "l" || b == "L") begin pos = 1; m_alarm = 1'b0; end
      else if (b == "a" || b == "A") begin pos = 1; m_alarm = 1'b1; end
      else if (b == "@") begin m_en = ~m_en; push_ev(3, c); end
    end else if (b == 8'h1b) begin
      pos = 0;
    end else if (pos <= 4) begin
      if (v >= 48 && v <= 48 + maxtab[pos-1]) begin
        m_dig[pos-1] = 4'(v - 48);
        pos++;
      end else begin
        push_ev(2, c);
        pos = 0;
      end
    end else begin
      if (b == TERM) begin
        m_bcd = {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
        push_ev(m_alarm ? 1 : 0, c);
      end else begin
        push_ev(2, c);
      end
      pos = 0;
    end
  endtask

  task automatic model_reset();
    pos = 0; m_en = EN_RST; m_bcd = 16'h0000;
    exp_q.delete();
    echo_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk12m);
    rx_data     = b;
    rx_data_rdy = 1'b1;
    model_step(b, cyc);
    echo_q.push_back(int'({b, 24'h0}) | (cyc + 1));
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk12m);
      rx_data_rdy = 1'b0;
      rx_data     = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_str(input string s, input int g);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      gap(g);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk12m);
    rst_n       = 1'b0;
    rx_data_rdy = 1'b0;
    model_reset();
    repeat (n) @(negedge clk12m);
    rst_n = 1'b1;
  endtask

  task automatic rand_byte_bad(input int i, output logic [7:0] b);
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0: b = 8'h1b;
      1: b = "@";
      2: b = 8'(48 + maxtab[i] + 1 + $urandom_range(0, 8 - maxtab[i]));
      default: b = 8'($urandom_range(0, 255));
    endcase
  endtask

  task automatic rand_cmd();
    int          r;
    logic [7:0]  b;
    logic [7:0]  cmds [4] = '{"l", "L", "a", "A"};
    r = $urandom_range(0, 9);
    if (r == 0) begin
      send("@"); gap($urandom_range(0, 2));
    end else if (r == 1) begin
      send(8'($urandom_range(0, 255))); gap($urandom_range(0, 2));
    end else begin
      send(cmds[$urandom_range(0, 3)]); gap($urandom_range(0, 2));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 99) < 90) b = 8'(48 + $urandom_range(0, maxtab[i]));
        else rand_byte_bad(i, b);
        send(b); gap($urandom_range(0, 2));
      end
      b = ($urandom_range(0, 99) < 90) ? TERM : 8'($urandom_range(0, 255));
      send(b); gap($urandom_range(0, 2));
    end
  endtask

  initial forever @(posedge clk12m) cyc++;

  // Monitor: pops the scoreboard whenever the DUT shows a strobe or an alarm_en change.
  initial begin : monitor
    logic        last_en;
    logic [15:0] mon_bcd;
    int          ns, kind;
    ev_t         e;
    last_en = EN_RST;
    mon_bcd = 16'h0000;
    forever begin
      @(negedge clk12m);
      if (!rst_n) begin
        last_en = EN_RST;
        mon_bcd = 16'h0000;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          n_chk++; n_err++;
          $display("FAIL missed_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
        end
        ns = int'(ld_time) + int'(ld_alarm) + int'(cmd_err);
        if (ns != 0) chk("strobe_onehot", 32'(ns), 32'd1);
        if (ns != 0 || alarm_en !== last_en) begin
          kind = ld_time ? 0 : ld_alarm ? 1 : cmd_err ? 2 : 3;
          if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            chk("alarm_en", 32'(alarm_en), 32'(e.en));
            if (e.kind <= 1) begin
              chk("bcd_on_load", 32'(bcd_val), 32'(e.bcd));
              mon_bcd = e.bcd;
            end
          end
        end
        chk("bcd_hold", 32'(bcd_val), 32'(mon_bcd));
        last_en = alarm_en;
`ifdef CMD_ECHO_EN
        if (tx_data_rdy) begin
          if (echo_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_echo: got %0h expected none", tx_data);
          end else begin
            int x;
            x = echo_q.pop_front();
            chk("echo_data", 32'(tx_data), 32'(x[31:24]));
            chk("echo_cycle", 32'(cyc), 32'(x[23:0]));
          end
        end
`else
        echo_q.delete();
`endif
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    repeat (3) @(negedge clk12m);
    rst_n = 1'b1;
    chk("rst_ld_time",  32'(ld_time),  32'd0);
    chk("rst_ld_alarm", 32'(ld_alarm), 32'd0);
    chk("rst_cmd_err",  32'(cmd_err),  32'd0);
    chk("rst_alarm_en", 32'(alarm_en), 32'(EN_RST));
    chk("rst_bcd",      32'(bcd_val),  32'd0);
`ifdef CMD_ECHO_EN
    chk("rst_tx_rdy",  32'(tx_data_rdy), 32'd0);
    chk("rst_tx_data", 32'(tx_data),     32'd0);
`endif
    gap(2);

    send_str("l5800\r", 1);
    gap(2);
    send_str("a5920\r", 0);
    gap(3);
    send("@"); gap(100);
    send("@"); gap(3);
    send_str("l6", 1);
    send_str("000\r", 1);
    gap(2);
    chk("bcd_after_err", 32'(bcd_val), 32'h5920);
    send_str("l12", 0);
    send(8'h1b);
    send_str("a0030\r", 0);
    gap(3);
    chk("bcd_after_esc", 32'(bcd_val), 32'h0030);

    send_str("l1", 1);
    do_reset(2);
    send_str("2", 1);
    send_str("00\r", 0);
    gap(3);
    chk("bcd_after_rst", 32'(bcd_val), 32'h0000);

    for (int k = 0; k < 400; k++) rand_cmd();
    send("@");
    send("@");
    gap(6);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
